// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for div/divu: fixed WIDTH+1 cycle latency,
// quotient for LO, remainder for HI, with per-request signed/unsigned selection.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_cancel,
    output logic             div_busy,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic             negQuot_q, negQuot_d;
    logic             negRem_q, negRem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remOut_q, remOut_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             lastStep;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             qBit;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuot;
    logic             src1Neg;
    logic             src2Neg;

    assign accept   = (state_q == IDLE || state_q == DONE) && div_start && !div_cancel;
    assign lastStep = (state_q == CALC) && (count_q == CW'(WIDTH - 1));

    // The quotient bits are shifted into the dividend register as it empties.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
    assign qBit     = ~diff[WIDTH+1];
    assign stepRem  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign stepQuot = {dvd_q[WIDTH-2:0], qBit};
    assign src1Neg  = div_signed & div_src1[WIDTH-1];
    assign src2Neg  = div_signed & div_src2[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (lastStep) state_d = DONE;
            DONE:    state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
        if (div_cancel) state_d = IDLE;
    end

    always_comb begin
        div_busy      = (state_q == CALC);
        div_valid     = (state_q == DONE);
        div_quotient  = quot_q;
        div_remainder = remOut_q;
        div_by_zero   = dbz_q;
    end

    always_comb begin
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        src1_d    = src1_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        zero_d    = zero_q;
        quot_d    = quot_q;
        remOut_d  = remOut_q;
        dbz_d     = dbz_q;
        if (div_cancel) begin
            count_d = '0;
        end else if (accept) begin
            count_d   = '0;
            rem_d     = '0;
            dvd_d     = src1Neg ? -div_src1 : div_src1;
            dvs_d     = src2Neg ? -div_src2 : div_src2;
            src1_d    = div_src1;
            negQuot_d = src1Neg ^ src2Neg;
            negRem_d  = src1Neg;
            zero_d    = (div_src2 == '0);
        end else if (state_q == CALC) begin
            count_d = count_q + CW'(1);
            rem_d   = stepRem;
            dvd_d   = stepQuot;
            // A zero divisor overrides sign correction with the fixed MIPS-style result.
            if (lastStep) begin
                if (zero_q) begin
                    quot_d   = '1;
                    remOut_d = src1_q;
                    dbz_d    = 1'b1;
                end else begin
                    quot_d   = negQuot_q ? -stepQuot : stepQuot;
                    remOut_d = negRem_q ? -stepRem : stepRem;
                    dbz_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            src1_q    <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            zero_q    <= 1'b0;
            quot_q    <= '0;
            remOut_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            src1_q    <= src1_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            zero_q    <= zero_d;
            quot_q    <= quot_d;
            remOut_q  <= remOut_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        div_busy;
    logic        div_valid;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_by_zero;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prevQ  = 32'd0;
    logic [31:0] prevR  = 32'd0;
    logic        prevZ  = 1'b0;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_cancel    (div_cancel),
        .div_busy      (div_busy),
        .div_valid     (div_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_by_zero   (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Truncating division from plain integer arithmetic, with the zero-divisor and overflow cases.
    function automatic void refDiv(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r, output logic z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to the valid cycle; returns while valid is still high.
    task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 input bit midStart, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          cycles;
        int          busyCnt;
        bit          held;
        refDiv(s, a, b, eq, er, ez);
        div_signed = s;
        div_src1   = a;
        div_src2   = b;
        div_start  = 1'b1;
        tick();
        div_start = 1'b0;
        cycles    = 1;
        busyCnt   = 0;
        held      = 1'b1;
        while (!div_valid && cycles < 100) begin
            if (div_busy) busyCnt++;
            if (div_quotient !== prevQ || div_remainder !== prevR || div_by_zero !== prevZ) held = 1'b0;
            if (midStart && cycles == 5) begin
                div_start  = 1'b1;
                div_signed = ~s;
                div_src1   = ~a;
                div_src2   = 32'd1;
            end else begin
                div_start = 1'b0;
            end
            tick();
            cycles++;
        end
        div_start = 1'b0;
        checkOutput({tag, "_valid"}, 32'(div_valid), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd33);
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd32);
        checkOutput({tag, "_busy_at_valid"}, 32'(div_busy), 32'd0);
        checkOutput({tag, "_held"}, 32'(held), 32'd1);
        checkOutput({tag, "_q"}, div_quotient, eq);
        checkOutput({tag, "_r"}, div_remainder, er);
        checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        prevQ = eq;
        prevR = er;
        prevZ = ez;
    endtask

    task automatic checkIdlePulseEnd(input string tag);
        tick();
        checkOutput({tag, "_pulse_end"}, 32'(div_valid), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(div_busy), 32'd0);
    endtask

    initial begin
        int nValid;
        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        div_cancel = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", 32'(div_busy), 32'd0);
        checkOutput("reset_valid", 32'(div_valid), 32'd0);
        checkOutput("reset_q", div_quotient, 32'd0);
        checkOutput("reset_r", div_remainder, 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, "u100_7");
        checkIdlePulseEnd("u100_7");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "s_m7_2");
        applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, "u_m7_2");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_ovf");
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_ovf");
        applyStimulus(1'b1, 32'h1234_5678, 32'd0, 1'b0, "s_dbz");
        checkIdlePulseEnd("s_dbz");
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, "midstart");
        checkIdlePulseEnd("midstart");

        // Cancel at count=10 with a colliding start, then a fresh 9/3.
        div_signed = 1'b0;
        div_src1   = 32'd1000;
        div_src2   = 32'd3;
        div_start  = 1'b1;
        tick();
        div_start = 1'b0;
        nValid    = 0;
        repeat (10) begin
            tick();
            if (div_valid) nValid++;
        end
        div_cancel = 1'b1;
        div_start  = 1'b1;
        div_src1   = 32'd55;
        div_src2   = 32'd5;
        tick();
        div_cancel = 1'b0;
        div_start  = 1'b0;
        checkOutput("cancel_busy", 32'(div_busy), 32'd0);
        checkOutput("cancel_valid", 32'(div_valid), 32'd0);
        checkOutput("cancel_novalid_before", 32'(nValid), 32'd0);
        checkOutput("cancel_q_held", div_quotient, prevQ);
        checkOutput("cancel_r_held", div_remainder, prevR);
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b0, "after_cancel");
        checkIdlePulseEnd("after_cancel");

        // Reset in the middle of an operation, with a start held alongside it.
        div_signed = 1'b1;
        div_src1   = 32'd12345;
        div_src2   = 32'd67;
        div_start  = 1'b1;
        tick();
        div_start = 1'b0;
        repeat (15) tick();
        rst       = 1'b1;
        div_start = 1'b1;
        tick();
        rst       = 1'b0;
        div_start = 1'b0;
        checkOutput("rst_mid_busy", 32'(div_busy), 32'd0);
        checkOutput("rst_mid_valid", 32'(div_valid), 32'd0);
        checkOutput("rst_mid_q", div_quotient, 32'd0);
        checkOutput("rst_mid_r", div_remainder, 32'd0);
        checkOutput("rst_mid_dbz", 32'(div_by_zero), 32'd0);
        prevQ  = 32'd0;
        prevR  = 32'd0;
        prevZ  = 1'b0;
        nValid = 0;
        repeat (40) begin
            tick();
            if (div_valid) nValid++;
        end
        checkOutput("rst_mid_novalid", 32'(nValid), 32'd0);

        // Back-to-back: the second start is issued in the first op's valid cycle.
        applyStimulus(1'b0, 32'd77, 32'd5, 1'b0, "b2b_first");
        applyStimulus(1'b1, 32'hFFFF_FF00, 32'd7, 1'b0, "b2b_second");
        checkIdlePulseEnd("b2b_second");

        for (int i = 0; i < 40; i++) begin
            bit          s;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> 16;
                4: b = -($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(s, a, b, 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) checkIdlePulseEnd($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Multi-cycle iterative divider that completes the `div`/`divu` path of the EX stage. The ALU produces only a combinational quotient/remainder pair; this block replaces it with a registered, fixed-latency radix-2 divider. The EX stage issues a request, stalls on `div_busy`, and takes quotient (LO) and remainder (HI) on `div_valid`. Signed and unsigned forms use the same 32-bit datapath, selected per request.

## Interface
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_start`  in  1  request strobe; sampled only when the unit is accepting (IDLE or DONE).
- `div_signed`  in  1  1 = `div` (two's complement), 0 = `divu`; captured with `div_start`.
- `div_src1`  in  WIDTH  dividend; captured with `div_start`.
- `div_src2`  in  WIDTH  divisor; captured with `div_start`.
- `div_cancel`  in  1  pipeline flush; aborts any operation in progress.
- `div_busy`  out  1  high while in CALC; EX holds its instruction while this is high.
- `div_valid`  out  1  one-cycle pulse; the result outputs are valid during this cycle.
- `div_quotient`  out  WIDTH  quotient, written to LO.
- `div_remainder`  out  WIDTH  remainder, written to HI.
- `div_by_zero`  out  1  result was produced with a zero divisor; valid alongside `div_valid`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `div_start`=1 and `div_cancel`=0:
  - Capture operands, the signed flag, and the zero-divisor flag.
  - Load the working dividend with |src1| and the divisor with |src2| when signed, or the raw values when unsigned.
  - Clear the partial remainder, set count=0, go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - count increments each step. The step at count=WIDTH-1 is the last one; on that edge the corrected results are registered and the state goes to DONE.
- Sign correction, applied combinationally at the final edge:
  - Quotient is negated iff signed and the operand signs differ.
  - Remainder is negated iff signed and the dividend is negative, giving truncating division (remainder takes the dividend's sign).
- Divide by zero, at the same latency: quotient = all ones, remainder = raw `div_src1`, `div_by_zero`=1. This overrides the sign correction.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 (natural wrap). No flag is raised.
- DONE:
  - `div_valid`=1 for exactly this cycle.
  - If `div_start`=1 in this cycle, a new operation is accepted exactly as from IDLE; otherwise go to IDLE.
- Result registers hold their last values until the next completion. They are unchanged by cancel.
- `div_cancel`=1 in any state:
  - Next state is IDLE, with no `div_valid`.
  - Cancel has priority over a simultaneous `div_start`; the start is dropped.
- `div_start` during CALC is ignored. Operands are used only as captured at acceptance.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, count 0, `div_busy`=0, `div_valid`=0, `div_quotient`=0, `div_remainder`=0, `div_by_zero`=0. Reset overrides cancel and start.
- Start accepted at edge E0:
  - `div_busy`=1 from after E0 through the cycle before E32.
  - The final step happens at edge E32 (WIDTH steps at E1..E32).
  - `div_valid`=1 in the cycle after E32; `div_busy`=0 in that cycle.
- Latency is a fixed WIDTH+1 = 33 cycles from the start-sample edge to the cycle in which `div_valid` is high, independent of operands.
- Back-to-back: a start asserted in the DONE cycle is accepted at that edge, so there is no bubble between operations.
- `rst` or `div_cancel` in the middle of CALC aborts within one edge; the unit accepts a new start on the following edge.

## Test plan
- Unsigned 100 / 7: start, then 33 cycles -> `div_valid`=1 with q=14, r=2, `div_by_zero`=0. `div_busy` is high for exactly 32 cycles.
- Signed 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Repeat as unsigned -> q=0x7FFFFFFC, r=1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. The same operands unsigned -> q=0, r=0x80000000.
- Divide by zero, 0x12345678 / 0, signed -> q=0xFFFFFFFF, r=0x12345678, `div_by_zero`=1, at the same 33-cycle latency.
- Assert `div_cancel` at count=10, then start 9 / 3 on the next cycle:
  - No valid pulse for the first operation.
  - The second operation yields q=3, r=0.
  - Results output previous values until then.
  - A start pulsed during CALC has no effect.
- `rst` asserted mid-CALC -> all outputs read 0 the next cycle and no valid pulse occurs. A back-to-back start in the DONE cycle produces two valid pulses exactly 33 cycles apart.
